// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control-unit / instruction-memory bundle for pc_sequencer
interface pc_sequencer_if #(
  parameter int W  = 16,
  parameter int JW = 12
);
  logic          en;
  logic [2:0]    sel;
  logic [W-1:0]  alu_target;
  logic [JW-1:0] jump_field;
  logic          clear_err;
  logic [W-1:0]  pc;
  logic [W-1:0]  pc_plus_inc;
  logic [W-1:0]  next_pc;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_ovf;
  logic          ras_unf;
  logic          misalign;

  modport master (
    output en, sel, alu_target, jump_field, clear_err,
    input  pc, pc_plus_inc, next_pc, ras_empty, ras_full, ras_ovf, ras_unf, misalign
  );

  modport slave (
    input  en, sel, alu_target, jump_field, clear_err,
    output pc, pc_plus_inc, next_pc, ras_empty, ras_full, ras_ovf, ras_unf, misalign
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered PC with next-PC select and return-address stack
// Optional target alignment check enabled by defining PC_SEQ_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter int             W         = 16,
  parameter int             JW        = 12,
  parameter int             INC       = 2,
  parameter int             DEPTH     = 4,
  parameter logic [W-1:0]   RESET_VEC = '0
) (
  input logic              CLK,
  input logic              Reset_n,
  pc_sequencer_if.slave    bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  localparam logic [2:0] SEL_ALU  = 3'd0;
  localparam logic [2:0] SEL_JUMP = 3'd1;
  localparam logic [2:0] SEL_CALL = 3'd3;
  localparam logic [2:0] SEL_RET  = 3'd4;

  logic [W-1:0]  pc_q;
  logic [W-1:0]  ppi;
  logic [W-1:0]  jump_tgt;
  logic [W-1:0]  ras_top;
  logic [W-1:0]  raw_tgt;
  logic [W-1:0]  nxt;
  logic [W-1:0]  stack [DEPTH];
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          ovf_q;
  logic          unf_q;
  logic          do_push;

  assign ppi      = pc_q + W'(INC);
  assign jump_tgt = {ppi[W-1:JW], bus.jump_field};
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign ras_top  = stack[IW'(count - CW'(1))];
  assign do_push  = bus.en && (bus.sel == SEL_CALL) && !full;

  always_comb begin
    raw_tgt = ppi;
    case (bus.sel)
      SEL_ALU:            raw_tgt = bus.alu_target;
      SEL_JUMP, SEL_CALL: raw_tgt = jump_tgt;
      SEL_RET:            raw_tgt = empty ? ppi : ras_top;
      default:            raw_tgt = ppi;
    endcase
  end

`ifdef PC_SEQ_ALIGN_CHECK_EN
  localparam logic [W-1:0] ALIGN_MASK = W'(INC - 1);
  logic tgt_chk;
  logic mis_set;
  logic mis_q;

  // an empty RET falls back to the increment, which is aligned by construction
  assign tgt_chk = (bus.sel == SEL_ALU) || (bus.sel == SEL_JUMP) || (bus.sel == SEL_CALL) ||
                   ((bus.sel == SEL_RET) && !empty);
  assign mis_set = tgt_chk && (|(raw_tgt & ALIGN_MASK));
  assign nxt     = tgt_chk ? (raw_tgt & ~ALIGN_MASK) : raw_tgt;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      mis_q <= 1'b0;
    end else if (bus.en && mis_set) begin
      mis_q <= 1'b1;
    end else if (bus.clear_err) begin
      mis_q <= 1'b0;
    end
  end
  assign bus.misalign = mis_q;
`else
  assign nxt          = raw_tgt;
  assign bus.misalign = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q  <= RESET_VEC;
      count <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      // a flag set on the same edge as clear_err overrides the clear
      if (bus.clear_err) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      if (bus.en) begin
        pc_q <= nxt;
        if (bus.sel == SEL_CALL) begin
          if (full) ovf_q <= 1'b1;
          else      count <= count + CW'(1);
        end else if (bus.sel == SEL_RET) begin
          if (empty) unf_q <= 1'b1;
          else       count <= count - CW'(1);
        end
      end
    end
  end

  // stack storage needs no reset: the count alone defines which entries are live
  always_ff @(posedge CLK) begin
    if (do_push) stack[IW'(count)] <= ppi;
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus_inc = ppi;
  assign bus.next_pc     = nxt;
  assign bus.ras_empty   = empty;
  assign bus.ras_full    = full;
  assign bus.ras_ovf     = ovf_q;
  assign bus.ras_unf     = unf_q;
endmodule
